// File: rtl/sprite_line_composer.sv
// sprite_line_composer: composes the next scanline of sprites into a double buffer while streaming the front buffer out
module sprite_line_composer #(
  parameter int SPRITE_SIZE = 16,
  parameter int H_ACTIVE    = 640,
  parameter int COLOR_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_line_start,
  input  logic [9:0]         i_next_line,
  input  logic [9:0]         i_h_cnt,
  input  logic               i_h_active,
  input  logic [9:0]         i_pacman_x,
  input  logic [9:0]         i_pacman_y,
  input  logic [9:0]         i_blinky_x,
  input  logic [9:0]         i_blinky_y,
  input  logic [9:0]         i_pinky_x,
  input  logic [9:0]         i_pinky_y,
  input  logic [9:0]         i_inky_x,
  input  logic [9:0]         i_inky_y,
  input  logic [9:0]         i_clyde_x,
  input  logic [9:0]         i_clyde_y,
  output logic [3:0]         o_which_char,
  input  logic [3:0]         i_pacman_pose,
  input  logic [3:0]         i_ghost_pose,
  output logic [14:0]        o_rom_addr,
  input  logic [COLOR_W-1:0] i_rom_data,
  output logic [COLOR_W-1:0] o_pixel,
  output logic               o_busy,
  output logic               o_overrun
);
  typedef enum logic [2:0] {IDLE, SELECT, FETCH, DRAIN, NEXT} state_e;
  state_e state_q, state_d;
  logic [2:0] char_q, char_d;
  logic [9:0] line_q, line_d, x_q, x_d;
  logic [3:0] pose_q, pose_d, row_q, row_d, col_q, col_d;
  logic front_q, front_d;
  logic overrun_q;
  logic wr_v_q;
  logic [10:0] wr_x_q;
  logic clr_v_q, clr_buf_q;
  logic [9:0] clr_x_q;
  logic [1:0] ls_cnt_q;
  logic [COLOR_W-1:0] pix_q;
  logic [COLOR_W-1:0] lbuf0 [H_ACTIVE];
  logic [COLOR_W-1:0] lbuf1 [H_ACTIVE];
  logic [9:0] sel_x, sel_y, row;
  logic hit, rd_en, wr_hit, clr_hit;
  logic [COLOR_W-1:0] rd_val;

  assign sel_x = char_q == 3'd0 ? i_pacman_x : char_q == 3'd1 ? i_blinky_x :
                 char_q == 3'd2 ? i_pinky_x  : char_q == 3'd3 ? i_inky_x : i_clyde_x;
  assign sel_y = char_q == 3'd0 ? i_pacman_y : char_q == 3'd1 ? i_blinky_y :
                 char_q == 3'd2 ? i_pinky_y  : char_q == 3'd3 ? i_inky_y : i_clyde_y;
  assign row = line_q - sel_y;
  assign hit = row < 10'(SPRITE_SIZE);

  assign o_which_char = {1'b0, char_q};
  assign o_rom_addr   = state_q == FETCH ? {char_q, pose_q, row_q, col_q} : '0;
  assign o_busy       = state_q != IDLE;
  assign o_overrun    = overrun_q;
  assign o_pixel      = pix_q;

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    line_d  = line_q;
    x_d     = x_q;
    pose_d  = pose_q;
    row_d   = row_q;
    col_d   = col_q;
    front_d = front_q;
    case (state_q)
      SELECT: begin
        state_d = hit ? FETCH : NEXT;
        x_d     = sel_x;
        pose_d  = char_q == 3'd0 ? i_pacman_pose : i_ghost_pose;
        row_d   = row[3:0];
        col_d   = '0;
      end
      FETCH: begin
        col_d   = col_q + 4'd1;
        state_d = col_q == 4'hf ? DRAIN : FETCH;
      end
      DRAIN: state_d = NEXT;
      NEXT: begin
        state_d = char_q == 3'd0 ? IDLE : SELECT;
        char_d  = char_q == 3'd0 ? char_q : char_q - 3'd1;
      end
      default: ;
    endcase
    // a new line always wins, even mid-composition (overrun)
    if (i_line_start) begin
      state_d = SELECT;
      char_d  = 3'd4;
      line_d  = i_next_line;
      front_d = ~front_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      char_q    <= '0;
      line_q    <= '0;
      x_q       <= '0;
      pose_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      front_q   <= 1'b0;
      overrun_q <= 1'b0;
      wr_v_q    <= 1'b0;
      wr_x_q    <= '0;
      clr_v_q   <= 1'b0;
      clr_x_q   <= '0;
      clr_buf_q <= 1'b0;
      ls_cnt_q  <= '0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      char_q    <= char_d;
      line_q    <= line_d;
      x_q       <= x_d;
      pose_q    <= pose_d;
      row_q     <= row_d;
      col_q     <= col_d;
      front_q   <= front_d;
      overrun_q <= i_line_start && state_q != IDLE;
      wr_v_q    <= state_q == FETCH && !i_line_start;
      wr_x_q    <= {1'b0, x_q} + {7'd0, col_q};
      clr_v_q   <= rd_en;
      clr_x_q   <= i_h_cnt;
      clr_buf_q <= front_q;
      ls_cnt_q  <= ls_cnt_q + 2'(i_line_start && ls_cnt_q != 2'd2);
      pix_q     <= (rd_en && ls_cnt_q == 2'd2) ? rd_val : '0;
    end
  end

  assign rd_en   = i_h_active && i_h_cnt < 10'(H_ACTIVE);
  assign rd_val  = front_q ? lbuf1[i_h_cnt] : lbuf0[i_h_cnt];
  assign wr_hit  = !i_rst && wr_v_q && i_rom_data != '0 && wr_x_q < 11'(H_ACTIVE);
  assign clr_hit = !i_rst && clr_v_q;

  // composition targets the back buffer, the delayed clear targets the buffer that was read
  always_ff @(posedge i_clk) begin
    if (wr_hit && front_q) lbuf0[wr_x_q[9:0]] <= i_rom_data;
    else if (clr_hit && !clr_buf_q) lbuf0[clr_x_q] <= '0;
    if (wr_hit && !front_q) lbuf1[wr_x_q[9:0]] <= i_rom_data;
    else if (clr_hit && clr_buf_q) lbuf1[clr_x_q] <= '0;
  end
endmodule

// File: tb/tb_sprite_line_composer.sv
// tb_sprite_line_composer: directed self-checking bench for sprite_line_composer
module tb_sprite_line_composer;
  logic clk, i_rst, i_line_start, i_h_active;
  logic [9:0] i_next_line, i_h_cnt;
  logic [9:0] xs [5];
  logic [9:0] ys [5];
  logic [3:0] o_which_char, i_pacman_pose, i_ghost_pose, rom_q, o_pixel;
  logic [14:0] o_rom_addr;
  logic o_busy, o_overrun;
  logic pac_hole;
  logic [3:0] exp_pix [640];
  logic [14:0] aq [$];
  int checks, errors;

  sprite_line_composer dut (
    .i_clk(clk), .i_rst(i_rst), .i_line_start(i_line_start), .i_next_line(i_next_line),
    .i_h_cnt(i_h_cnt), .i_h_active(i_h_active),
    .i_pacman_x(xs[0]), .i_pacman_y(ys[0]), .i_blinky_x(xs[1]), .i_blinky_y(ys[1]),
    .i_pinky_x(xs[2]), .i_pinky_y(ys[2]), .i_inky_x(xs[3]), .i_inky_y(ys[3]),
    .i_clyde_x(xs[4]), .i_clyde_y(ys[4]), .o_which_char(o_which_char),
    .i_pacman_pose(i_pacman_pose), .i_ghost_pose(i_ghost_pose), .o_rom_addr(o_rom_addr),
    .i_rom_data(rom_q), .o_pixel(o_pixel), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] rom_fn(input logic [14:0] a);
    if (a[14:12] == 3'd0) return (pac_hole && a[3:0] >= 4 && a[3:0] <= 7) ? 4'd0 : 4'd5;
    return 4'(a[14:12]) + 4'd5;
  endfunction

  assign i_ghost_pose = o_which_char + 4'd1;
  always @(posedge clk) rom_q <= rom_fn(o_rom_addr);
  always @(negedge clk) if (o_rom_addr != 0) aq.push_back(o_rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic park();
    for (int c = 0; c < 5; c++) begin
      xs[c] = 10'd0;
      ys[c] = 10'd600;
    end
    pac_hole = 0;
  endtask

  task automatic place(input int c, input int x, input int y);
    xs[c] = 10'(x);
    ys[c] = 10'(y);
  endtask

  task automatic fill(input int lo, input int hi, input logic [3:0] v);
    for (int i = lo; i <= hi; i++) exp_pix[i] = v;
  endtask

  task automatic pulse(input logic [9:0] l);
    @(negedge clk);
    i_line_start = 1;
    i_next_line = l;
    @(negedge clk);
    i_line_start = 0;
  endtask

  task automatic compose(input string tag, input logic [9:0] l, input int exp_busy);
    int n;
    aq.delete();
    pulse(l);
    n = 0;
    while (o_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_busy);
  endtask

  task automatic sweep(input bit chk);
    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      if (k > 0 && chk) check($sformatf("pix%0d", k - 1), o_pixel, exp_pix[k - 1]);
      i_h_cnt = 10'(k);
      i_h_active = 1;
    end
    @(negedge clk);
    if (chk) check("pix639", o_pixel, exp_pix[639]);
    i_h_active = 0;
    @(negedge clk);
    check("pix_inactive", o_pixel, 0);
    fill(0, 639, 0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    i_rst = 1;
    i_line_start = 0;
    i_next_line = 0;
    i_h_cnt = 0;
    i_h_active = 0;
    i_pacman_pose = 4'd3;
    park();
    fill(0, 639, 0);
    repeat (3) @(negedge clk);
    check("rst_which", o_which_char, 0);
    check("rst_addr", o_rom_addr, 0);
    check("rst_pixel", o_pixel, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovr", o_overrun, 0);
    i_rst = 0;
    // basic fetch
    place(0, 100, 50);
    compose("busy_basic", 55, 27);
    check("basic_naddr", aq.size(), 16);
    for (int i = 0; i < aq.size(); i++) check($sformatf("basic_addr%0d", i), aq[i], 15'h0350 + 15'(i));
    sweep(1);
    compose("busy_miss500", 500, 10);
    check("miss500_naddr", aq.size(), 0);
    fill(100, 115, 5);
    sweep(1);
    sweep(1);
    // overlap priority
    place(0, 200, 10);
    place(1, 200, 10);
    pac_hole = 1;
    compose("busy_overlap", 10, 44);
    sweep(1);
    compose("busy_ov_next", 500, 10);
    fill(200, 215, 5);
    fill(204, 207, 6);
    sweep(1);
    // right-edge clip
    park();
    place(4, 630, 300);
    compose("busy_clip", 300, 27);
    sweep(1);
    compose("busy_clip_next", 500, 10);
    fill(630, 639, 9);
    sweep(1);
    // vertical wrap
    park();
    place(3, 300, 1020);
    compose("busy_wrap", 3, 27);
    check("wrap_naddr", aq.size(), 16);
    for (int i = 0; i < aq.size(); i++) check($sformatf("wrap_addr%0d", i), aq[i], 15'h3470 + 15'(i));
    sweep(1);
    compose("busy_wrap_next", 500, 10);
    fill(300, 315, 8);
    sweep(1);
    // misses just above and just below
    place(3, 300, 40);
    compose("busy_miss39", 39, 10);
    check("miss39_naddr", aq.size(), 0);
    sweep(1);
    compose("busy_miss56", 56, 10);
    check("miss56_naddr", aq.size(), 0);
    sweep(1);
    // overrun with every character hitting
    place(0, 10, 100);
    place(1, 18, 100);
    place(2, 100, 100);
    place(3, 300, 100);
    place(4, 630, 100);
    pac_hole = 1;
    pulse(100);
    repeat (28) @(negedge clk);
    check("pre_ovr_busy", o_busy, 1);
    pulse(100);
    check("ovr_hi", o_overrun, 1);
    check("ovr_char", o_which_char, 4);
    n = 1;
    @(negedge clk);
    check("ovr_lo", o_overrun, 0);
    while (o_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("busy_ovr", n, 95);
    sweep(0);
    compose("busy_ovr_next", 500, 10);
    fill(10, 13, 5);
    fill(18, 25, 5);
    fill(26, 33, 6);
    fill(100, 115, 7);
    fill(300, 315, 8);
    fill(630, 639, 9);
    sweep(1);
    // reset mid-fetch
    park();
    place(0, 100, 50);
    pulse(55);
    n = 0;
    while (o_rom_addr == 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("rstf_first_addr", o_rom_addr, 15'h0350);
    repeat (3) @(negedge clk);
    i_rst = 1;
    @(negedge clk);
    check("rstf_busy", o_busy, 0);
    check("rstf_addr", o_rom_addr, 0);
    check("rstf_which", o_which_char, 0);
    check("rstf_pixel", o_pixel, 0);
    check("rstf_ovr", o_overrun, 0);
    i_rst = 0;
    repeat (3) @(negedge clk);
    check("rstf_idle", o_busy, 0);
    check("rstf_idle_addr", o_rom_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_line_composer.md
# sprite_line_composer

Scanline sprite compositor for Pac-Man and the four ghosts. During each display line it prepares the next line: it steps `o_which_char` through the characters, captures the pose index returned by the animation pose selector, fetches the matching 16-pixel sprite row from sprite ROM and writes it into a double-buffered line buffer. During active video it streams the front buffer to the pixel mixer, clearing each entry as it is read.

## Interface
- `SPRITE_SIZE`, 16: sprite width and height in pixels; fixed, since row and column fields are 4 bits.
- `H_ACTIVE`, 640: active pixels per line, which is also the line buffer depth.
- `COLOR_W`, 4: colour index width; colour index 0 is transparent.

- `i_clk`  in  1  system clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_line_start`  in  1  one-cycle pulse that swaps the buffers and starts composition of `i_next_line`
- `i_next_line`  in  10  screen line to compose; sampled on `i_line_start`
- `i_h_cnt`  in  10  horizontal pixel counter from the VGA timing block
- `i_h_active`  in  1  active-video qualifier for `i_h_cnt`
- `i_pacman_x/_y`, `i_blinky_x/_y`, `i_pinky_x/_y`, `i_inky_x/_y`, `i_clyde_x/_y`  in  10 each  sprite top-left coordinates
- `o_which_char`  out  4  character being queried: 0 = Pac-Man, 1 = Blinky, 2 = Pinky, 3 = Inky, 4 = Clyde
- `i_pacman_pose`  in  4  combinational pose returned by the pose selector
- `i_ghost_pose`  in  4  combinational pose for the ghost selected by `o_which_char`
- `o_rom_addr`  out  15  sprite ROM address, formed as {char[2:0], pose[3:0], row[3:0], col[3:0]}
- `i_rom_data`  in  COLOR_W  ROM output, valid 1 cycle after the address
- `o_pixel`  out  COLOR_W  sprite colour index, 0 = no sprite
- `o_busy`  out  1  composition in progress
- `o_overrun`  out  1  one-cycle pulse when `i_line_start` arrives while `o_busy` is high

## Operation
- **Buffers:** two H_ACTIVE x COLOR_W buffers, designated front (being read) and back (being composed). Each `i_line_start` swaps the designations.
- **Character order:** 4, 3, 2, 1, 0. Later writes overwrite earlier ones, so Pac-Man has the highest priority and Clyde the lowest.
- **IDLE:** waits for `i_line_start`. On the pulse it latches `i_next_line`, sets char = 4, asserts `o_busy`, and goes to SELECT.
- **SELECT (1 cycle):**
  - Drives `o_which_char` = char.
  - Captures the pose: `i_pacman_pose` when char = 0, otherwise `i_ghost_pose`.
  - Computes `row = (line − char_y) mod 1024` (10-bit unsigned subtraction).
  - If `row < 16` (hit), goes to FETCH with col = 0. On a miss, goes to NEXT.
- **FETCH (16 cycles):** issues `o_rom_addr` = {char, pose, row[3:0], col} for col = 0..15.
- **Writeback:** occurs one cycle after each address. Writes back[x+col] = `i_rom_data` only if `i_rom_data != 0` and `x+col < H_ACTIVE`. The sum `x+col` is computed at 11 bits, so there is no wrap.
- **DRAIN (1 cycle):** completes the last writeback, then goes to NEXT.
- **NEXT:** if char = 0, goes to IDLE and deasserts `o_busy`. Otherwise it decrements char and returns to SELECT.
- **Readout:** while `i_h_active` is high and `i_h_cnt < H_ACTIVE`:
  - Reads front[`i_h_cnt`].
  - Clears front[`i_h_cnt`] to 0 one cycle later.
- **Overrun:** if `i_line_start` arrives while busy, the block pulses `o_overrun`, abandons the current composition (partial line is kept), swaps buffers and restarts at char = 4 with the new line.

## Timing
- **Composition length:**
  - Hit character: 18 cycles (SELECT + 16 FETCH + DRAIN).
  - Missed character: 1 cycle.
  - NEXT: 1 cycle per character.
  - Worst case: 5 × 19 = 95 cycles after `i_line_start`.
- **`o_busy`:** rises the cycle after `i_line_start` and falls the cycle after the final NEXT.
- **Pose sampling:** the pose inputs are sampled in the same cycle `o_which_char` is driven. Both are combinational, so no wait state is needed.
- **Readout latency:** `o_pixel` is registered and reflects `i_h_cnt` from the previous cycle. It is 0 the cycle after `i_h_active` is low.
- **Reset values:** `o_which_char` = 0, `o_rom_addr` = 0, `o_pixel` = 0, `o_busy` = 0, `o_overrun` = 0, FSM in IDLE, front = buffer 0.
- **Buffer contents after reset:** undefined. `o_pixel` is forced to 0 until the second `i_line_start` after reset, by which point both buffers have been cleared by readout.
- **Reset mid-composition:** returns the FSM to IDLE in the next cycle; no further buffer writes occur.

## Test plan
- **Basic fetch:** Pac-Man at (100, 50), `i_next_line` = 55, pose 3, ROM returns colour 5 → ROM addresses {0, 3, 5, 0..15}. On the next line `o_pixel` = 5 for `i_h_cnt` 100..115 and 0 elsewhere. `o_busy` is high for 1 + 4 + 18 + 4 = 27 cycles.
- **Overlap priority:** Blinky and Pac-Man both at (200, 10), line 10 → pixels 200..215 show Pac-Man's colours. Where Pac-Man's ROM returns 0, Blinky's colour shows through.
- **Right-edge clip:** Clyde at x = 630 → pixels 630..639 are written; nothing is written to indices ≥ 640 and no wrap to index 0.
- **Vertical wrap and miss:**
  - Inky at y = 1020, line 3 → row 7 is fetched.
  - Inky at y = 40, line 39 or 56 → no ROM fetch.
- **Overrun:** second `i_line_start` 30 cycles after the first, with all characters hitting → `o_overrun` is high for 1 cycle and composition restarts at char 4.
- **Reset and clear-on-read:**
  - `i_rst` asserted mid-FETCH → all outputs are 0 the next cycle and the FSM is IDLE.
  - A line that was displayed once reads as all zeros if it is displayed again without recomposition.
